// File: rtl/sine_phase_gen.sv
// Phase accumulator front end for sine_table: emits a sine ID and a quarter-turn
// offset cosine ID per sample over a valid/ready handshake, in bursts or free-run.
module sine_phase_gen #(
   parameter int ROM_DEPTH = 64,
   parameter int ADDRW     = $clog2(4*ROM_DEPTH),
   parameter int ACCW      = 16,
   parameter int CNTW      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [ACCW-1:0]  inc,
   input  logic [ACCW-1:0]  phase_init,
   input  logic [CNTW-1:0]  count,
   input  logic             ready,
   output logic             valid,
   output logic [ADDRW-1:0] id,
   output logic [ADDRW-1:0] id_cos,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [ADDRW-1:0] QUARTER = ADDRW'(ROM_DEPTH);

   state_t            state_q, state_d;
   logic [ACCW-1:0]   acc_q, acc_d;
   logic [ACCW-1:0]   inc_q, inc_d;
   logic [CNTW-1:0]   remaining_q, remaining_d;
   logic              free_run_q, free_run_d;
   logic              stop_pend_q, stop_pend_d;
   logic              done_q, done_d;
   logic              last_sample;

   // A burst of count 0 never decrements and only ends on a stop request.
   assign last_sample = (!free_run_q && remaining_q == CNTW'(1)) || stop_pend_q || stop;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      inc_d       = inc_q;
      remaining_d = remaining_q;
      free_run_d  = free_run_q;
      stop_pend_d = stop_pend_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d       = phase_init;
               inc_d       = inc;
               remaining_d = count;
               free_run_d  = (count == '0);
               stop_pend_d = 1'b0;
               state_d     = RUN;
            end
         end
         RUN: begin
            if (ready) begin
               if (last_sample) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  acc_d = acc_q + inc_q;
                  if (!free_run_q) begin
                     remaining_d = remaining_q - CNTW'(1);
                  end
               end
            end else if (stop) begin
               stop_pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         inc_q       <= '0;
         remaining_q <= '0;
         free_run_q  <= 1'b0;
         stop_pend_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         inc_q       <= inc_d;
         remaining_q <= remaining_d;
         free_run_q  <= free_run_d;
         stop_pend_q <= stop_pend_d;
         done_q      <= done_d;
      end
   end

   assign valid  = (state_q == RUN);
   assign busy   = (state_q == RUN);
   assign done   = done_q;
   assign id     = acc_q[ACCW-1 -: ADDRW];
   assign id_cos = id + QUARTER;

endmodule

// File: tb/tb_sine_phase_gen.sv
// Directed self-checking bench for sine_phase_gen (ROM_DEPTH=64, ADDRW=8, ACCW=16).
module tb_sine_phase_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] inc = '0;
   logic [15:0] phase_init = '0;
   logic [15:0] count = '0;
   logic        ready = 1'b0;
   logic        valid;
   logic [7:0]  id;
   logic [7:0]  id_cos;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_ids [8];

   sine_phase_gen #(.ROM_DEPTH(64), .ADDRW(8), .ACCW(16), .CNTW(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .inc(inc),
      .phase_init(phase_init), .count(count), .ready(ready), .valid(valid),
      .id(id), .id_cos(id_cos), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [15:0] p0, input logic [15:0] stp, input logic [15:0] n);
      phase_init = p0;
      inc        = stp;
      count      = n;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   // Runs a burst with ready held high, checking each sample then the ending done pulse.
   task automatic run_burst(input string name, input logic [15:0] p0, input logic [15:0] stp,
                            input int n);
      logic [7:0] ecos;
      ready = 1'b1;
      pulse_start(p0, stp, 16'(n));
      for (int i = 0; i < n; i++) begin
         ecos = exp_ids[i] + 8'd64;
         n_cmp++;
         if ({valid, busy, done, id, id_cos} !== {3'b110, exp_ids[i], ecos}) begin
            n_err++;
            $display("[TB] FAIL %s sample %0d: v/b/d=%b%b%b id=%0d cos=%0d, required 110 id=%0d cos=%0d",
                     name, i, valid, busy, done, id, id_cos, exp_ids[i], ecos);
         end
         tick();
      end
      n_cmp++;
      if ({valid, busy, done} !== 3'b001) begin
         n_err++;
         $display("[TB] FAIL %s end: v/b/d=%b%b%b, required 001", name, valid, busy, done);
      end
      tick();
      n_cmp++;
      if ({valid, busy, done} !== 3'b000) begin
         n_err++;
         $display("[TB] FAIL %s after-done: v/b/d=%b%b%b, required 000", name, valid, busy, done);
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({valid, busy, done, id, id_cos} !== {3'b000, 8'd0, 8'd64}) begin
         n_err++;
         $display("[TB] FAIL reset: v/b/d=%b%b%b id=%0d cos=%0d, required 000 id=0 cos=64",
                  valid, busy, done, id, id_cos);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_burst();
      exp_ids = '{8'd63, 8'd64, 8'd65, 8'd66, 8'd0, 8'd0, 8'd0, 8'd0};
      run_burst("burst", 16'h3F00, 16'h0100, 4);
   endtask

   task automatic test_wrap();
      exp_ids = '{8'd255, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      run_burst("wrap", 16'hFF00, 16'h0100, 3);
   endtask

   task automatic test_fractional();
      exp_ids = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0};
      run_burst("fractional", 16'h0000, 16'h0080, 5);
   endtask

   task automatic test_negative_step();
      exp_ids = '{8'd2, 8'd1, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
      run_burst("negstep", 16'h0200, 16'hFF00, 4);
   endtask

   task automatic test_backpressure();
      logic [7:0] want;
      ready = 1'b1;
      pulse_start(16'h0000, 16'h0100, 16'd5);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               tick();
               n_cmp++;
               if ({valid, done, id} !== {2'b10, 8'd2}) begin
                  n_err++;
                  $display("[TB] FAIL backpressure hold %0d: valid=%b done=%b id=%0d, required valid=1 done=0 id=2",
                           k, valid, done, id);
               end
            end
            ready = 1'b1;
         end
         want = 8'(i);
         n_cmp++;
         if ({valid, id} !== {1'b1, want}) begin
            n_err++;
            $display("[TB] FAIL backpressure sample %0d: valid=%b id=%0d, required valid=1 id=%0d",
                     i, valid, id, want);
         end
         tick();
      end
      n_cmp++;
      if ({valid, busy, done} !== 3'b001) begin
         n_err++;
         $display("[TB] FAIL backpressure end: v/b/d=%b%b%b, required 001", valid, busy, done);
      end
      tick();
   endtask

   task automatic test_stop();
      ready = 1'b1;
      pulse_start(16'h1000, 16'h0100, 16'd0);
      tick();
      tick();
      ready = 1'b0;
      stop  = 1'b1;
      tick();
      stop  = 1'b0;
      n_cmp++;
      if ({valid, busy, done, id} !== {3'b110, 8'd18}) begin
         n_err++;
         $display("[TB] FAIL stop pending: v/b/d=%b%b%b id=%0d, required 110 id=18", valid, busy, done, id);
      end
      phase_init = 16'h8000;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if ({valid, id} !== {1'b1, 8'd18}) begin
         n_err++;
         $display("[TB] FAIL start-in-run: valid=%b id=%0d, required valid=1 id=18", valid, id);
      end
      ready = 1'b1;
      tick();
      n_cmp++;
      if ({valid, busy, done} !== 3'b001) begin
         n_err++;
         $display("[TB] FAIL stop end: v/b/d=%b%b%b, required 001", valid, busy, done);
      end
      tick();
      pulse_start(16'h2000, 16'h0100, 16'd0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_cmp++;
      if ({valid, busy, done} !== 3'b001) begin
         n_err++;
         $display("[TB] FAIL stop-with-handshake: v/b/d=%b%b%b, required 001", valid, busy, done);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_cmp++;
      if ({valid, busy, done} !== 3'b000) begin
         n_err++;
         $display("[TB] FAIL stop-in-idle: v/b/d=%b%b%b, required 000", valid, busy, done);
      end
   endtask

   task automatic test_back_to_back();
      ready = 1'b1;
      pulse_start(16'h0500, 16'h0100, 16'd1);
      tick();
      n_cmp++;
      if ({valid, done} !== 2'b01) begin
         n_err++;
         $display("[TB] FAIL b2b first done: valid=%b done=%b, required valid=0 done=1", valid, done);
      end
      ready = 1'b0;
      stop  = 1'b1;
      pulse_start(16'h0A00, 16'h0100, 16'd2);
      stop  = 1'b0;
      n_cmp++;
      if ({valid, done, id} !== {2'b10, 8'd10}) begin
         n_err++;
         $display("[TB] FAIL b2b restart: valid=%b done=%b id=%0d, required valid=1 done=0 id=10",
                  valid, done, id);
      end
      ready = 1'b1;
      tick();
      n_cmp++;
      if ({valid, id} !== {1'b1, 8'd11}) begin
         n_err++;
         $display("[TB] FAIL b2b second: valid=%b id=%0d, required valid=1 id=11", valid, id);
      end
      tick();
      n_cmp++;
      if ({valid, done} !== 2'b01) begin
         n_err++;
         $display("[TB] FAIL b2b end: valid=%b done=%b, required valid=0 done=1", valid, done);
      end
      tick();
   endtask

   task automatic test_reset_mid_burst();
      ready = 1'b1;
      pulse_start(16'h3F00, 16'h0100, 16'd4);
      tick();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({valid, busy, done, id, id_cos} !== {3'b000, 8'd0, 8'd64}) begin
         n_err++;
         $display("[TB] FAIL reset mid-burst: v/b/d=%b%b%b id=%0d cos=%0d, required 000 id=0 cos=64",
                  valid, busy, done, id, id_cos);
      end
      tick();
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (done !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL reset no-done: done=%b, required 0", done);
      end
      exp_ids = '{8'd63, 8'd64, 8'd65, 8'd66, 8'd0, 8'd0, 8'd0, 8'd0};
      run_burst("post-reset", 16'h3F00, 16'h0100, 4);
   endtask

   initial begin
      test_reset();
      test_burst();
      test_wrap();
      test_fractional();
      test_negative_step();
      test_backpressure();
      test_stop();
      test_back_to_back();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
